// File: rtl/muldiv_unit_if.sv
// Request/response bundle between a requester and the iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] RA;
  logic [WIDTH-1:0] RB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_by_zero;

  modport master (
    output start, op, RA, RB,
    input  busy, done, HI, LO, div_by_zero
  );

  modport slave (
    input  start, op, RA, RB,
    output busy, done, HI, LO, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract step per
// cycle on operand magnitudes, sign-corrected into HI/LO when the last step completes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_sx;
  logic             r_sa;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;
  logic             r_done;
  logic             r_busy;

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic is_signed);
    logic signed [WIDTH-1:0] v_s;
    v_s = v;
    return f_neg_w(v, is_signed && (v_s < 0));
  endfunction

  logic [WIDTH:0]     w_add;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_fin_hi;
  logic [WIDTH-1:0]   w_fin_lo;
  logic               w_last;
  logic               w_dbz_req;

  // Multiply step: conditional add of the multiplicand, then shift {acc, q} right by one
  assign w_add    = r_acc + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_hi = w_add[WIDTH:1];
  assign w_mul_q  = {w_add[0], r_q[WIDTH-1:1]};
  assign w_prod   = f_neg_2w({w_mul_hi, w_mul_q}, r_op[0] & r_sx);

  // Divide step: remainder stays below the divisor, so bit WIDTH of the difference is the borrow
  assign w_shift  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem    = w_ge ? w_diff : w_shift;
  assign w_quo    = {r_q[WIDTH-2:0], w_ge};

  assign w_fin_hi = r_op[1] ? f_neg_w(w_rem[WIDTH-1:0], r_op[0] & r_sa) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fin_lo = r_op[1] ? f_neg_w(w_quo, r_op[0] & r_sx) : w_prod[WIDTH-1:0];
  assign w_last   = (r_cnt == CW'(1));
  assign w_dbz_req = bus.op[1] && (bus.RB == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sx    <= 1'b0;
      r_sa    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op   <= bus.op;
            r_b    <= f_abs(bus.op[1] ? bus.RB : bus.RA, bus.op[0]);
            r_q    <= f_abs(bus.op[1] ? bus.RA : bus.RB, bus.op[0]);
            r_acc  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_sx   <= bus.RA[WIDTH-1] ^ bus.RB[WIDTH-1];
            r_sa   <= bus.RA[WIDTH-1];
            r_busy <= 1'b1;
            if (w_dbz_req) begin
              r_state <= DONE;
              r_hi    <= bus.RA;
              r_lo    <= '1;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= bus.op[1] ? DIV : MUL;
              r_dbz   <= 1'b0;
            end
          end
        end
        MUL, DIV: begin
          r_acc <= (r_state == MUL) ? {1'b0, w_mul_hi} : w_rem;
          r_q   <= (r_state == MUL) ? w_mul_q : w_quo;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_hi    <= w_fin_hi;
            r_lo    <= w_fin_lo;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.HI          = r_hi;
  assign bus.LO          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected results, a monitor checks them on done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           c0;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_HI"}, 64'(bus.HI), 64'(e.hi));
        chk({e.tag, "_LO"}, 64'(bus.LO), 64'(e.lo));
        chk({e.tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
        chk({e.tag, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz,
                        input int pulse_at, input string tag);
    exp_t e;
    int n;
    wait_idle();
    bus.op = op;
    bus.RA = a;
    bus.RB = b;
    bus.start = 1'b1;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.c0 = cyc + 1; e.lat = dbz ? 0 : W; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = ~op;
    bus.RA = ~a;
    bus.RB = '0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.start = (pulse_at != 0 && n == pulse_at);
      if (bus.busy === 1'b1) n++;
      else break;
    end
    bus.start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), dbz ? 64'd1 : 64'd33);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.RA = '0;
    bus.RB = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("reset_HILO", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0, "mult_m3x5");
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, "multu_max");
    run_op(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, "div_m7d2");
    run_op(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 0, "divu_100d7");
    run_op(2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 0, "divu_by0");
    repeat (4) @(negedge clk);
    chk("dbz_held", 64'(bus.div_by_zero), 64'd1);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, "div_ovf");
    run_op(2'b01, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0, "mult_7xm6");
    run_op(2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 0, "div_7dm2");
    run_op(2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 0, "multu_2p32");
    run_op(2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 0, "divu_max");
    run_op(2'b11, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 0, "div_by0");
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 0, "mult_m1xm1");
    repeat (5) @(negedge clk);
    chk("hold_HILO", {bus.HI, bus.LO}, 64'h00000000_00000001);

    // A start pulse mid-operation must be ignored
    run_op(2'b01, 32'd1000, 32'hFFFFFC18, 32'hFFFFFFFF, 32'hFFF0BDC0, 1'b0, 10, "mult_start_ignored");

    // Reset partway through a multiply aborts it with no done pulse
    wait_idle();
    bus.op = 2'b01;
    bus.RA = 32'd12345;
    bus.RB = 32'd678;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("abort_HILO", {bus.HI, bus.LO}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_result", {bus.HI, bus.LO}, 64'd0);

    run_op(2'b01, 32'd12345, 32'd678, 32'd0, 32'd8369910, 1'b0, 0, "mult_after_reset");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 2 bits: operation select.
  - 00 = MULTU
  - 01 = MULT (signed)
  - 10 = DIVU
  - 11 = DIV (signed)
REQ-006 Port RA, input, WIDTH bits: register-file read port A, used as multiplicand or dividend.
REQ-007 Port RB, input, WIDTH bits: register-file read port B, used as multiplier or divisor.
REQ-008 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 Port done, output, 1 bit: high for exactly one cycle while in DONE.
REQ-010 Port HI, output, WIDTH bits: product upper half, or remainder.
REQ-011 Port LO, output, WIDTH bits: product lower half, or quotient.
REQ-012 Port div_by_zero, output, 1 bit: set with done when a divide had RB == 0; held until the next accepted start.

Function
REQ-013 States SHALL be IDLE, MUL, DIV and DONE.
REQ-014 IDLE with start=1 at a clock edge SHALL perform all of the following:
  - latch op
  - latch |RA| and |RB| (absolute value when signed, raw when unsigned)
  - latch the result-sign and remainder-sign flags
  - load the iteration counter with WIDTH
  - clear div_by_zero
  - enter MUL for op[1]=0, or DIV for op[1]=1
REQ-015 Divide with RB == 0 SHALL bypass DIV and go straight to DONE with HI=RA, LO=all ones, div_by_zero=1.
REQ-016 MUL SHALL perform one shift-add iteration per cycle; DIV SHALL perform one restoring shift-subtract iteration per cycle; both decrement the counter.
REQ-017 On the edge where the counter reaches 0, the block SHALL enter DONE and update HI/LO with the sign-corrected result.
REQ-018 Latency SHALL be as follows:
  - normal operation: done high in the cycle after start-edge + WIDTH edges (32 for WIDTH=32)
  - divide by zero: done high one edge after the start edge
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start SHALL be ignored when not in IDLE.
REQ-021 RA, RB and op changes after acceptance SHALL NOT affect the operation in progress.
REQ-022 MULT SHALL produce the two's-complement 2*WIDTH-bit product {HI,LO}; MULTU SHALL produce the unsigned product.
REQ-023 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 DIV with most-negative / -1 SHALL give LO = 1 followed by WIDTH-1 zeros (0x80000000) and HI = 0, with no error flag.
REQ-025 HI/LO SHALL hold their value between operations and change only on entry to DONE.
REQ-026 Internal accumulator/remainder SHALL be WIDTH+1 bits wide so no carry or borrow is lost.

Reset
REQ-027 Asserting reset at any time SHALL immediately:
  - force IDLE
  - clear busy, done, div_by_zero
  - clear HI, LO, the counter and all internal operand registers
REQ-028 Reset mid-operation SHALL abort with no done pulse.
REQ-029 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-030 MULT RA=0xFFFFFFFD (-3), RB=5 -> after 32 cycles: done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-031 MULTU RA=RB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, busy high for 33 cycles total.
REQ-032 DIV RA=0xFFFFFFF9 (-7), RB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU RA=100, RB=7 -> LO=14, HI=2.
REQ-033 DIVU RA=100, RB=0 -> done one cycle later, div_by_zero=1, HI=100, LO=0xFFFFFFFF.
REQ-034 DIV RA=0x80000000, RB=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
REQ-035 Pulse start again at cycle 10 of a MULT -> ignored, result unchanged; assert reset at cycle 15 -> outputs zero, no done, next start completes correctly.
